// File: rtl/datach_barcode_ser.sv
`default_nettype none
// ============================================================================
// Module   : datach_barcode_ser
// Purpose  : Serialises an EAN-8 / EAN-13 barcode from a 13-digit buffer as a
//            stream of modules (1 = bar), framed by quiet zones. Each module
//            lasts BIT_TICKS pulses of the tick timing base.
// Ports    : clk, rst_n        clock, asynchronous active-low reset
//            tick              one-clk timing pulse
//            dig_we/addr/dat   digit buffer write port (ignored while busy)
//            len13             1 = EAN-13, 0 = EAN-8 (sampled at start)
//            start             one-clk scan request
//            busy              scan in progress
//            bc_out            current module value, registered
//            done              one-clk pulse at end of scan
// Revision : 1.0  initial release
// ============================================================================
module datach_barcode_ser #(
  parameter int BIT_TICKS = 1000,
  parameter int QUIET     = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       dig_we,
  input  logic [3:0] dig_addr,
  input  logic [3:0] dig_dat,
  input  logic       len13,
  input  logic       start,
  output logic       busy,
  output logic       bc_out,
  output logic       done
);

  localparam int TW   = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int MAXM = (QUIET > 95) ? QUIET : 95;
  localparam int MW   = $clog2(MAXM);

  localparam logic [TW-1:0] TICK_LAST  = TW'(BIT_TICKS - 1);
  localparam logic [MW-1:0] QUIET_LAST = MW'(QUIET - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LEAD = 2'd1, DATA = 2'd2, TRAIL = 2'd3} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tick_cnt, tick_cnt_nx;
  logic [MW-1:0] mod_cnt, mod_cnt_nx;
  logic          len13_q, len13_nx;
  logic          bc_nx, done_nx;

  logic [3:0]    dig_buf [0:12];

  // Symbol generator signals
  logic [6:0] sym_idx, rel, left_end, centre_end, right_end;
  logic [2:0] dg, bp;
  logic [3:0] digit;
  logic [5:0] par;
  logic [6:0] code;
  logic       sym_bit;

  // L-code table; out-of-range digit values encode as 0.
  function automatic logic [6:0] lcode(input logic [3:0] d);
    case (d)
      4'd1:    lcode = 7'b0011001;
      4'd2:    lcode = 7'b0010011;
      4'd3:    lcode = 7'b0111101;
      4'd4:    lcode = 7'b0100011;
      4'd5:    lcode = 7'b0110001;
      4'd6:    lcode = 7'b0101111;
      4'd7:    lcode = 7'b0111011;
      4'd8:    lcode = 7'b0110111;
      4'd9:    lcode = 7'b0001011;
      default: lcode = 7'b0001101;
    endcase
  endfunction

  // EAN-13 left-half parity, bit 5 = digit 1, 1 selects the G code.
  function automatic logic [5:0] parity(input logic [3:0] d);
    case (d)
      4'd1:    parity = 6'b001011;
      4'd2:    parity = 6'b001101;
      4'd3:    parity = 6'b001110;
      4'd4:    parity = 6'b010011;
      4'd5:    parity = 6'b011001;
      4'd6:    parity = 6'b011100;
      4'd7:    parity = 6'b010101;
      4'd8:    parity = 6'b010110;
      4'd9:    parity = 6'b011010;
      default: parity = 6'b000000;
    endcase
  endfunction

  function automatic logic [6:0] rev7(input logic [6:0] v);
    for (int i = 0; i < 7; i++) rev7[i] = v[6-i];
  endfunction

  assign busy = (state != IDLE);

  // Buffer is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (dig_we && !busy && (dig_addr <= 4'd12)) dig_buf[dig_addr] <= dig_dat;
  end

  // Index of the module that becomes current after the next module boundary.
  assign sym_idx    = (state == DATA) ? (mod_cnt[6:0] + 7'd1) : 7'd0;
  assign left_end   = len13_q ? 7'd45 : 7'd31;
  assign centre_end = len13_q ? 7'd50 : 7'd36;
  assign right_end  = len13_q ? 7'd92 : 7'd64;

  always_comb begin
    sym_bit = 1'b0;
    rel     = 7'd0;
    dg      = 3'd0;
    bp      = 3'd0;
    digit   = 4'd0;
    code    = 7'd0;
    par     = parity(dig_buf[0]);
    if (sym_idx < 7'd3) begin
      sym_bit = ~sym_idx[0];                       // guard 101
    end else if (sym_idx < left_end) begin
      rel   = sym_idx - 7'd3;
      dg    = 3'(rel / 7'd7);
      bp    = 3'(rel % 7'd7);
      digit = dig_buf[len13_q ? ({1'b0, dg} + 4'd1) : {1'b0, dg}];
      code  = lcode(digit);
      if (len13_q && par[3'd5 - dg]) code = rev7(~code);
      sym_bit = code[3'd6 - bp];
    end else if (sym_idx < centre_end) begin
      rel     = sym_idx - left_end;
      sym_bit = rel[0];                            // centre 01010
    end else if (sym_idx < right_end) begin
      rel     = sym_idx - centre_end;
      dg      = 3'(rel / 7'd7);
      bp      = 3'(rel % 7'd7);
      digit   = dig_buf[(len13_q ? 4'd7 : 4'd4) + {1'b0, dg}];
      code    = ~lcode(digit);
      sym_bit = code[3'd6 - bp];
    end else begin
      rel     = sym_idx - right_end;
      sym_bit = ~rel[0];                           // guard 101
    end
  end

  // Next-state / output logic
  always_comb begin
    state_nx    = state;
    tick_cnt_nx = tick_cnt;
    mod_cnt_nx  = mod_cnt;
    len13_nx    = len13_q;
    bc_nx       = bc_out;
    done_nx     = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        state_nx    = LEAD;
        tick_cnt_nx = '0;
        mod_cnt_nx  = '0;
        len13_nx    = len13;
        bc_nx       = 1'b0;
      end
    end else if (tick) begin
      if (tick_cnt != TICK_LAST) begin
        tick_cnt_nx = tick_cnt + TW'(1);
      end else begin
        tick_cnt_nx = '0;
        mod_cnt_nx  = mod_cnt + MW'(1);
        case (state)
          LEAD: begin
            if (mod_cnt == QUIET_LAST) begin
              state_nx   = DATA;
              mod_cnt_nx = '0;
              bc_nx      = sym_bit;
            end
          end
          DATA: begin
            if (mod_cnt == (len13_q ? MW'(94) : MW'(66))) begin
              state_nx   = TRAIL;
              mod_cnt_nx = '0;
              bc_nx      = 1'b0;
            end else begin
              bc_nx = sym_bit;
            end
          end
          default: begin
            if (mod_cnt == QUIET_LAST) begin
              state_nx   = IDLE;
              mod_cnt_nx = '0;
              done_nx    = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      mod_cnt  <= '0;
      len13_q  <= 1'b0;
      bc_out   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick_cnt_nx;
      mod_cnt  <= mod_cnt_nx;
      len13_q  <= len13_nx;
      bc_out   <= bc_nx;
      done     <= done_nx;
    end
  end

endmodule
`default_nettype wire
